// File: rtl/processor_mem_stream_writer.sv
// processor_mem_stream_writer
//   Packs an incoming byte stream (valid/ready) into little-endian 32-bit words
//   and writes them to a single-port memory, starting at a programmed base
//   address and wrapping at DEPTH. A transfer ends after num_words words or
//   early on flush (any partial word is written with only its filled lanes).
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, base_addr, num_words  transfer request, sampled only in IDLE
//   flush                        end transfer early (honoured only in FILL)
//   in_data, in_valid, in_ready  byte stream handshake
//   mem_*                        memory write port, driven only in WRITE
//   busy, done, err              status: active transfer, completion pulse,
//                                rejected-start pulse
//   words_written                words written in current/last transfer
module processor_mem_stream_writer #(
  parameter int unsigned DEPTH  = 5120,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              flush,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_written
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [31:0]       word_q, word_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      num_q        <= '0;
      words_q      <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      num_q        <= num_d;
      words_q      <= words_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    num_d          = num_q;
    words_d        = words_q;
    word_d         = word_q;
    cnt_d          = cnt_q;
    flush_pend_d   = flush_pend_q;
    err_d          = 1'b0;
    in_ready       = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (base_addr > LAST_ADDR) begin
            err_d = 1'b1;
          end else if (num_words == '0) begin
            words_d = '0;
            state_d = DONE;
          end else begin
            addr_d  = base_addr;
            num_d   = num_words;
            words_d = '0;
            cnt_d   = '0;
            word_d  = '0;
            state_d = FILL;
          end
        end
      end

      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d[{cnt_q[1:0], 3'b000} +: 8] = in_data;
          cnt_d = cnt_q + 3'd1;
        end
        // A flush that arrives with a byte still includes that byte.
        if (flush && (in_valid || cnt_q != 3'd0)) begin
          flush_pend_d = 1'b1;
          state_d      = WRITE;
        end else if (flush) begin
          state_d = DONE;
        end else if (in_valid && cnt_q == 3'd3) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = addr_q;
        mem_writedata  = word_q;
        case (cnt_q)
          3'd1:    mem_byteenable = 4'b0001;
          3'd2:    mem_byteenable = 4'b0011;
          3'd3:    mem_byteenable = 4'b0111;
          default: mem_byteenable = 4'b1111;
        endcase
        words_d = words_q + 1'b1;
        addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        word_d  = '0;
        cnt_d   = '0;
        if (flush_pend_q || (words_q + 1'b1) == num_q) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end

      DONE: begin
        done         = 1'b1;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign err           = err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_processor_mem_stream_writer.sv
module tb_processor_mem_stream_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] base_addr = '0;
  logic [12:0] num_words = '0;
  logic        flush = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        busy;
  logic        done;
  logic        err;
  logic [12:0] words_written;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];

  processor_mem_stream_writer #(.DEPTH(5120), .ADDR_W(13)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .words_written  (words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory-port monitor: every write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (mem_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {19'd0, mem_address}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {19'd0, mem_address}, {19'd0, e.addr});
        check("wr_data", mem_writedata, e.data);
        check("wr_be", {28'd0, mem_byteenable}, {28'd0, e.be});
        check("wr_cs", {31'd0, mem_chipselect}, 32'd1);
      end
    end else if (mem_chipselect || mem_byteenable != 4'd0 || mem_writedata != 32'd0 || mem_address != 13'd0) begin
      check("mem_idle_zero", {mem_chipselect, mem_byteenable, mem_writedata[26:0]}, 32'd0);
    end
  end

  task automatic push(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a; e.data = d; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [12:0] b, input logic [12:0] n);
    start = 1'b1; base_addr = b; num_words = n;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    int n;
    n = 0;
    in_data = b; in_valid = 1'b1; flush = fl;
    while (!in_ready && n < 20) begin step(); n++; end
    if (n >= 20) check("in_ready_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_done(input logic [12:0] exp_ww);
    int n;
    n = 0;
    while (!done && n < 50) begin step(); n++; end
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("words_written", {19'd0, words_written}, {19'd0, exp_ww});
    step();
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_ww", {19'd0, words_written}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    reset_n = 1'b1;
    step();

    // 1: two full words from base 0
    push(13'd0, 32'h04030201, 4'b1111);
    push(13'd1, 32'h08070605, 4'b1111);
    do_start(13'd0, 13'd2);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    wait_done(13'd2);

    // 2: address wrap at DEPTH-1
    push(13'd5119, 32'h14131211, 4'b1111);
    push(13'd0,    32'h18171615, 4'b1111);
    do_start(13'd5119, 13'd2);
    for (int i = 'h11; i <= 'h18; i++) send(8'(i), 1'b0);
    wait_done(13'd2);

    // 3: separate flush after two bytes
    push(13'd10, 32'h0000BBAA, 4'b0011);
    do_start(13'd10, 13'd4);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_done(13'd1);

    // 4: flush together with the third byte
    push(13'd20, 32'h00CCBBAA, 4'b0111);
    do_start(13'd20, 13'd4);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    wait_done(13'd1);

    // 5a: out-of-range base rejected; words_written holds
    do_start(13'd5120, 13'd1);
    check("t5_err", {31'd0, err}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ww_hold", {19'd0, words_written}, 32'd1);
    step();
    check("t5_err_pulse", {31'd0, err}, 32'd0);
    check("t5_stay_idle", {30'd0, busy, in_ready}, 32'd0);
    // 5b: zero-length transfer
    do_start(13'd3, 13'd0);
    check("t5_err_none", {31'd0, err}, 32'd0);
    wait_done(13'd0);

    // 6: reset mid-FILL, then a clean transfer
    do_start(13'd100, 13'd2);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_ready", {31'd0, in_ready}, 32'd0);
    check("t6_ww", {19'd0, words_written}, 32'd0);
    check("t6_mem", {mem_write, mem_chipselect, mem_byteenable, mem_writedata[25:0]}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    push(13'd100, 32'h04030201, 4'b1111);
    do_start(13'd100, 13'd1);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    wait_done(13'd1);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
